// File: rtl/pingpong_transposer_pkg.sv
// Shared types for the ping-pong block transposer.
// A block is four rows of four elements; row r word holds col c in lane c.
package transposer_pkg;

  localparam int LANES  = 4;
  localparam int ELEM_W = 16;

  typedef logic [ELEM_W-1:0] elem_t;
  typedef elem_t [LANES-1:0] row_t;
  typedef row_t  [LANES-1:0] block_t;

  typedef enum logic {
    RD_IDLE,
    RD_RUN
  } rd_state_t;

endpackage

// File: rtl/pingpong_transposer_skew.sv
// Per-lane delay line: D skew stages plus the output register.
// Data is forced to zero whenever its valid bit is low.
module lane_skew_pipe
  import transposer_pkg::*;
#(
  parameter int D = 0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  in_valid,
  input  elem_t in_data,
  output logic  out_valid,
  output elem_t out_data
);

  localparam int N = D + 1;

  if (D < 0 || D > 3) begin : g_depth_chk
    $error("lane_skew_pipe: D must be 0..3");
  end

  logic  [N-1:0] vld_q, vld_d;
  elem_t [N-1:0] dat_q, dat_d;

  always_comb begin
    vld_d[0] = in_valid;
    dat_d[0] = in_valid ? in_data : '0;
    for (int i = 1; i < N; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    if (clr) begin
      vld_d = '0;
      dat_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_valid = vld_q[N-1];
  assign out_data  = dat_q[N-1];

endmodule

// File: rtl/pingpong_transposer.sv
// Two 4x4 banks: one fills row by row while the other replays as
// columns or rows, optionally skewed into a systolic wavefront.
module pingpong_transposer
  import transposer_pkg::elem_t;
  import transposer_pkg::row_t;
  import transposer_pkg::block_t;
  import transposer_pkg::rd_state_t;
  import transposer_pkg::RD_IDLE;
  import transposer_pkg::RD_RUN;
#(
  parameter int LANES   = 4,
  parameter int ELEM_W  = 16,
  parameter bit SKEW_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    bank_sel,
  input  logic                    transpose,
  input  logic                    in_valid,
  input  logic [LANES*ELEM_W-1:0] data_in,
  output logic [LANES*ELEM_W-1:0] data_out,
  output logic [LANES-1:0]        lane_valid,
  output logic                    overrun
);

  if (LANES != 4 || ELEM_W != transposer_pkg::ELEM_W) begin : g_param_chk
    $error("pingpong_transposer: LANES must be 4, ELEM_W must match pkg");
  end

  block_t [1:0] bank_q, bank_d;
  logic   [1:0] full_q, full_d;
  logic   [1:0] wr_ptr_q, wr_ptr_d;
  logic         overrun_q, overrun_d;

  rd_state_t    state_q, state_d;
  logic         rd_bank_q, rd_bank_d;
  logic         rd_mode_q, rd_mode_d;
  logic   [1:0] rd_ptr_q, rd_ptr_d;

  logic         iss_vld;
  logic         iss_bank;
  logic         iss_mode;
  logic   [1:0] iss_idx;
  logic         rd_done;
  row_t         iss_row;
  row_t         din;
  logic         wr_en;

  assign din   = row_t'(data_in);
  assign wr_en = in_valid & ~clr;

  // Idle issues index 0 in the same cycle it claims a bank.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_mode_d = rd_mode_q;
    rd_ptr_d  = rd_ptr_q;
    iss_vld   = 1'b0;
    iss_bank  = rd_bank_q;
    iss_mode  = rd_mode_q;
    iss_idx   = rd_ptr_q;
    rd_done   = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[~bank_sel]) begin
          iss_vld   = 1'b1;
          iss_bank  = ~bank_sel;
          iss_mode  = transpose;
          iss_idx   = 2'd0;
          rd_bank_d = ~bank_sel;
          rd_mode_d = transpose;
          rd_ptr_d  = 2'd1;
          state_d   = RD_RUN;
        end
      end
      RD_RUN: begin
        iss_vld  = 1'b1;
        rd_ptr_d = rd_ptr_q + 2'd1;
        if (rd_ptr_q == 2'd3) begin
          rd_done = 1'b1;
          state_d = RD_IDLE;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (clr) begin
      state_d  = RD_IDLE;
      rd_ptr_d = 2'd0;
      iss_vld  = 1'b0;
      rd_done  = 1'b0;
    end
  end

  // Full flag is judged before this edge's clear, so a collision drops.
  always_comb begin
    bank_d    = bank_q;
    full_d    = full_q;
    wr_ptr_d  = wr_ptr_q;
    overrun_d = overrun_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
      if (full_q[bank_sel]) begin
        overrun_d = 1'b1;
      end else begin
        bank_d[bank_sel][wr_ptr_q] = din;
        if (wr_ptr_q == 2'd3) full_d[bank_sel] = 1'b1;
      end
    end
    if (clr) begin
      full_d    = '0;
      wr_ptr_d  = 2'd0;
      overrun_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      iss_row[i] = iss_mode ? bank_q[iss_bank][i][iss_idx]
                            : bank_q[iss_bank][iss_idx][i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q    <= '0;
      full_q    <= '0;
      wr_ptr_q  <= '0;
      overrun_q <= 1'b0;
      state_q   <= RD_IDLE;
      rd_bank_q <= 1'b0;
      rd_mode_q <= 1'b0;
      rd_ptr_q  <= '0;
    end else begin
      bank_q    <= bank_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_mode_q <= rd_mode_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  assign overrun = overrun_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    elem_t lane_data;
    lane_skew_pipe #(
      .D(SKEW_EN ? i : 0)
    ) u_pipe (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .in_valid (iss_vld),
      .in_data  (iss_row[i]),
      .out_valid(lane_valid[i]),
      .out_data (lane_data)
    );
    assign data_out[i*ELEM_W +: ELEM_W] = lane_data;
  end

endmodule

// File: tb/tb_pingpong_transposer.sv
// Bench: aligned and skewed instances against a block-level model.
// Model schedules each replayed element at issue+1+skew.
module tb_pingpong_transposer;

  localparam int NC = 2048;

  logic        clk = 1'b0;
  logic        rst, clr, bank_sel, transpose, in_valid;
  logic [63:0] data_in;
  logic [63:0] dout0, dout1;
  logic [3:0]  lv0, lv1;
  logic        ovr0, ovr1;

  always #5 clk = ~clk;

  pingpong_transposer #(.LANES(4), .ELEM_W(16), .SKEW_EN(1'b0)) u_flat (
    .clk(clk), .rst(rst), .clr(clr), .bank_sel(bank_sel),
    .transpose(transpose), .in_valid(in_valid), .data_in(data_in),
    .data_out(dout0), .lane_valid(lv0), .overrun(ovr0)
  );

  pingpong_transposer #(.LANES(4), .ELEM_W(16), .SKEW_EN(1'b1)) u_skew (
    .clk(clk), .rst(rst), .clr(clr), .bank_sel(bank_sel),
    .transpose(transpose), .in_valid(in_valid), .data_in(data_in),
    .data_out(dout1), .lane_valid(lv1), .overrun(ovr1)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] m_bank [2][4][4];
  bit          m_full [2];
  int          m_clr_at [2];
  int          m_wptr;
  bit          m_ovr;
  int          m_rd_free;
  logic [15:0] e_d [2][NC][4];
  bit          e_v [2][NC][4];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_reset(int from, bit banks);
    for (int t = from; t < NC; t++)
      for (int s = 0; s < 2; s++)
        for (int i = 0; i < 4; i++) begin
          e_v[s][t][i] = 1'b0;
          e_d[s][t][i] = '0;
        end
    for (int b = 0; b < 2; b++) begin
      m_full[b]   = 1'b0;
      m_clr_at[b] = -1;
      if (banks)
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) m_bank[b][r][c] = '0;
    end
    m_wptr    = 0;
    m_ovr     = 1'b0;
    m_rd_free = 0;
  endfunction

  function automatic void model_step();
    bit          old_full [2];
    bit          setf [2];
    int          nb, sb, t;
    logic [15:0] val;
    if (rst || clr) begin
      model_reset(cyc + 1, rst);
      return;
    end
    old_full = m_full;
    setf     = '{1'b0, 1'b0};
    nb       = bank_sel ? 0 : 1;
    sb       = bank_sel ? 1 : 0;
    if (cyc >= m_rd_free && old_full[nb]) begin
      for (int k = 0; k < 4; k++)
        for (int i = 0; i < 4; i++) begin
          val = transpose ? m_bank[nb][i][k] : m_bank[nb][k][i];
          for (int s = 0; s < 2; s++) begin
            t = cyc + k + 1 + (s == 1 ? i : 0);
            e_v[s][t][i] = 1'b1;
            e_d[s][t][i] = val;
          end
        end
      m_rd_free    = cyc + 4;
      m_clr_at[nb] = cyc + 3;
    end
    if (in_valid) begin
      if (old_full[sb]) begin
        m_ovr = 1'b1;
      end else begin
        for (int c = 0; c < 4; c++) m_bank[sb][m_wptr][c] = data_in[16*c +: 16];
        if (m_wptr == 3) setf[sb] = 1'b1;
      end
      m_wptr = (m_wptr + 1) % 4;
    end
    for (int b = 0; b < 2; b++) begin
      if (m_clr_at[b] == cyc) begin
        m_full[b]   = 1'b0;
        m_clr_at[b] = -1;
      end
      if (setf[b]) m_full[b] = 1'b1;
    end
  endfunction

  task automatic check_outputs();
    logic [63:0] ed;
    logic [3:0]  ev;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        ed[16*i +: 16] = e_d[s][cyc][i];
        ev[i]          = e_v[s][cyc][i];
      end
      chk(s == 1 ? "dout_skew" : "dout_flat", s == 1 ? dout1 : dout0, ed);
      chk(s == 1 ? "lv_skew" : "lv_flat", s == 1 ? lv1 : lv0, ev);
    end
    chk("ovr_flat", ovr0, m_ovr);
    chk("ovr_skew", ovr1, m_ovr);
  endtask

  task automatic drive(bit v, logic [63:0] d, bit s, bit tr, bit cl, bit rs);
    in_valid  = v;
    data_in   = d;
    bank_sel  = s;
    transpose = tr;
    clr       = cl;
    rst       = rs;
  endtask

  task automatic half();
    @(negedge clk);
    check_outputs();
    model_step();
  endtask

  task automatic finish_cyc();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick(bit v, logic [63:0] d, bit s, bit tr, bit cl, bit rs);
    drive(v, d, s, tr, cl, rs);
    half();
    finish_cyc();
  endtask

  function automatic logic [63:0] row_word(int r);
    logic [63:0] w;
    for (int c = 0; c < 4; c++) w[16*c +: 16] = 16'(r * 16 + c);
    return w;
  endfunction

  initial begin
    int base, run, best, rows;
    logic [3:0] acc;
    bit s, v, cl, tr;

    drive(0, '0, 0, 0, 0, 1);
    model_reset(0, 1);
    tick(0, '0, 0, 0, 0, 1);
    tick(0, '0, 0, 0, 0, 1);
    chk("rst_dout", dout1, 64'h0);
    chk("rst_ovr", ovr0, 1'b0);

    // transpose, aligned and skewed
    base = cyc;
    for (int k = 0; k < 14; k++) begin
      if (k < 4) tick(1, row_word(k), 0, 1, 0, 0);
      else       tick(0, '0, 1, 1, 0, 0);
      case (cyc - base)
        5: begin
          chk("tr_c5", dout0, 64'h0030_0020_0010_0000);
          chk("tr_lv5", lv0, 4'hF);
          chk("sk_lv5", lv1, 4'h1);
        end
        8: begin
          chk("tr_c8", dout0, 64'h0033_0023_0013_0003);
          chk("tr_lv8", lv0, 4'hF);
          chk("sk_l3_c8", dout1[63:48], 16'h0030);
        end
        9:  chk("tr_lv9", lv0, 4'h0);
        11: chk("sk_lv11", lv1, 4'h8);
        default: ;
      endcase
    end

    // pass-through
    base = cyc;
    for (int k = 0; k < 12; k++) begin
      if (k < 4) tick(1, row_word(k), 0, 0, 0, 0);
      else       tick(0, '0, 1, 0, 0, 0);
      if (cyc - base == 5) chk("pt_c5", dout0, 64'h0003_0002_0001_0000);
    end

    // continuous three-block stream
    run  = 0;
    best = 0;
    for (int k = 0; k < 22; k++) begin
      if (k < 12)
        tick(1, row_word(k % 4) | {4{16'((k / 4 + 1) << 8)}}, 1'((k / 4) % 2), 1, 0, 0);
      else
        tick(0, '0, 1, 1, 0, 0);
      run  = (lv0 == 4'hF) ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    chk("stream_run", 64'(best), 64'd12);
    chk("stream_ovr", ovr0, 1'b0);

    // overrun: fifth row into a full bank is dropped
    base = cyc;
    for (int k = 0; k < 17; k++) begin
      if (k < 4)       tick(1, row_word(k), 0, 1, 0, 0);
      else if (k == 4) tick(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0);
      else             tick(0, '0, 1, 1, 0, 0);
      if (cyc - base == 5) chk("ovr_set", ovr0, 1'b1);
      if (cyc - base == 6) chk("ovr_data", dout0, 64'h0030_0020_0010_0000);
    end
    tick(0, '0, 1, 1, 1, 0);
    chk("ovr_clr", ovr1, 1'b0);

    // clr drops a full bank
    for (int k = 0; k < 4; k++) tick(1, row_word(k), 0, 1, 0, 0);
    tick(0, '0, 0, 1, 1, 0);
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      tick(0, '0, 1, 1, 0, 0);
      acc |= lv0 | lv1;
    end
    chk("clr_full", acc, 4'h0);

    // async reset in the middle of a read-out
    for (int k = 0; k < 6; k++) begin
      if (k < 4) tick(1, row_word(k), 0, 1, 0, 0);
      else       tick(0, '0, 1, 1, 0, 0);
    end
    drive(0, '0, 1, 1, 0, 0);
    half();
    rst = 1'b1;
    #1;
    chk("arst_dout", dout0, 64'h0);
    chk("arst_lv", lv1, 4'h0);
    model_reset(cyc + 1, 1);
    finish_cyc();
    tick(0, '0, 1, 1, 0, 1);
    acc = '0;
    for (int k = 0; k < 10; k++) begin
      tick(0, '0, 1, 1, 0, 0);
      acc |= lv0 | lv1;
    end
    chk("post_rst_lv", acc, 4'h0);

    // randomized traffic, occasional clr and missed toggles
    rows = 0;
    s    = 1'b0;
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 63) == 0);
      tr = 1'($urandom_range(0, 1));
      tick(v, {$urandom, $urandom}, s, tr, cl, 0);
      if (cl) begin
        rows = 0;
      end else if (v) begin
        rows++;
        if (rows == 4) begin
          rows = 0;
          if ($urandom_range(0, 7) != 0) s = ~s;
        end
      end
    end
    for (int k = 0; k < 12; k++) tick(0, '0, s, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
